// File: rtl/myaccip_axil_arbiter_if.sv
// AXI4-Lite channel bundle used for both requester ports and the shared slave port.
// Every channel moves a beat on a rising edge where valid and ready are both high; valid
// never waits on ready, and the payload holds steady from the rise of valid to the handshake.
interface myaccip_axil_arbiter_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [2:0]              arprot;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awprot, awvalid,
        input  awready,
        output wdata, wstrb, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready,
        output araddr, arprot, arvalid,
        input  arready,
        input  rdata, rresp, rvalid,
        output rready
    );

    modport slave (
        input  awaddr, awprot, awvalid,
        output awready,
        input  wdata, wstrb, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready,
        input  araddr, arprot, arvalid,
        output arready,
        output rdata, rresp, rvalid,
        input  rready
    );
endinterface

// File: rtl/myaccip_axil_arbiter.sv
// Two-requester round-robin AXI4-Lite arbiter in front of the myaccip register port.
// Whole transactions are serialised; the granted requester is remembered for response routing.
module myaccip_axil_arbiter #(
    parameter int ADDR_WIDTH  = 4,
    parameter int DATA_WIDTH  = 32,
    parameter bit WRITE_FIRST = 1'b1
) (
    input  logic                   ACLK,
    input  logic                   ARESETN,
    myaccip_axil_arbiter_if.slave  s0_axi,
    myaccip_axil_arbiter_if.slave  s1_axi,
    myaccip_axil_arbiter_if.master m_axi,
    output logic [2:0]             dbg_state_o,
    output logic                   dbg_gnt_o,
    output logic                   dbg_prio_o
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_RESP = 3'd4
    } state_e;

    state_e state_q, state_d;
    logic   gnt_q, gnt_d;
    logic   prio_q, prio_d;
    logic   aw_done_q, aw_done_d;
    logic   w_done_q, w_done_d;

    logic [1:0] wr_req;
    logic [1:0] rd_req;
    logic       has_prio;
    logic       win_sel;
    logic       win_has;
    logic       win_wr;

    logic [ADDR_WIDTH-1:0] g_awaddr;
    logic [ADDR_WIDTH-1:0] g_araddr;
    logic [2:0]            g_awprot;
    logic [2:0]            g_arprot;
    logic [DATA_WIDTH-1:0] g_wdata;
    logic [STRB_WIDTH-1:0] g_wstrb;
    logic                  g_bready;
    logic                  g_rready;

    logic in_wr_req, in_wr_resp, in_rd_req, in_rd_resp;
    logic m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready;
    logic aw_hs, w_hs, ar_hs, b_hs, r_hs;
    logic g_awready, g_wready, g_arready, g_bvalid, g_rvalid;

    // A write only counts once both its address and data are offered.
    assign wr_req = {s1_axi.awvalid & s1_axi.wvalid, s0_axi.awvalid & s0_axi.wvalid};
    assign rd_req = {s1_axi.arvalid, s0_axi.arvalid};

    always_comb begin
        has_prio = wr_req[prio_q] | rd_req[prio_q];
        win_sel  = has_prio ? prio_q : ~prio_q;
        win_has  = wr_req[win_sel] | rd_req[win_sel];
        if (WRITE_FIRST) begin
            win_wr = wr_req[win_sel];
        end else begin
            win_wr = wr_req[win_sel] & ~rd_req[win_sel];
        end
    end

    assign g_awaddr = gnt_q ? s1_axi.awaddr : s0_axi.awaddr;
    assign g_awprot = gnt_q ? s1_axi.awprot : s0_axi.awprot;
    assign g_wdata  = gnt_q ? s1_axi.wdata  : s0_axi.wdata;
    assign g_wstrb  = gnt_q ? s1_axi.wstrb  : s0_axi.wstrb;
    assign g_bready = gnt_q ? s1_axi.bready : s0_axi.bready;
    assign g_araddr = gnt_q ? s1_axi.araddr : s0_axi.araddr;
    assign g_arprot = gnt_q ? s1_axi.arprot : s0_axi.arprot;
    assign g_rready = gnt_q ? s1_axi.rready : s0_axi.rready;

    assign in_wr_req  = (state_q == WR_REQ);
    assign in_wr_resp = (state_q == WR_RESP);
    assign in_rd_req  = (state_q == RD_REQ);
    assign in_rd_resp = (state_q == RD_RESP);

    // Valids come from registered state only; readies and responses pass straight through.
    assign m_awvalid = in_wr_req & ~aw_done_q;
    assign m_wvalid  = in_wr_req & ~w_done_q;
    assign m_arvalid = in_rd_req;
    assign m_bready  = in_wr_resp & g_bready;
    assign m_rready  = in_rd_resp & g_rready;

    assign aw_hs = m_awvalid & m_axi.awready;
    assign w_hs  = m_wvalid & m_axi.wready;
    assign ar_hs = m_arvalid & m_axi.arready;
    assign b_hs  = in_wr_resp & m_axi.bvalid & g_bready;
    assign r_hs  = in_rd_resp & m_axi.rvalid & g_rready;

    assign g_awready = m_awvalid & m_axi.awready;
    assign g_wready  = m_wvalid & m_axi.wready;
    assign g_arready = m_arvalid & m_axi.arready;
    assign g_bvalid  = in_wr_resp & m_axi.bvalid;
    assign g_rvalid  = in_rd_resp & m_axi.rvalid;

    assign m_axi.awaddr  = g_awaddr;
    assign m_axi.awprot  = g_awprot;
    assign m_axi.awvalid = m_awvalid;
    assign m_axi.wdata   = g_wdata;
    assign m_axi.wstrb   = g_wstrb;
    assign m_axi.wvalid  = m_wvalid;
    assign m_axi.bready  = m_bready;
    assign m_axi.araddr  = g_araddr;
    assign m_axi.arprot  = g_arprot;
    assign m_axi.arvalid = m_arvalid;
    assign m_axi.rready  = m_rready;

    assign s0_axi.awready = g_awready & ~gnt_q;
    assign s0_axi.wready  = g_wready & ~gnt_q;
    assign s0_axi.bvalid  = g_bvalid & ~gnt_q;
    assign s0_axi.bresp   = m_axi.bresp;
    assign s0_axi.arready = g_arready & ~gnt_q;
    assign s0_axi.rvalid  = g_rvalid & ~gnt_q;
    assign s0_axi.rdata   = m_axi.rdata;
    assign s0_axi.rresp   = m_axi.rresp;

    assign s1_axi.awready = g_awready & gnt_q;
    assign s1_axi.wready  = g_wready & gnt_q;
    assign s1_axi.bvalid  = g_bvalid & gnt_q;
    assign s1_axi.bresp   = m_axi.bresp;
    assign s1_axi.arready = g_arready & gnt_q;
    assign s1_axi.rvalid  = g_rvalid & gnt_q;
    assign s1_axi.rdata   = m_axi.rdata;
    assign s1_axi.rresp   = m_axi.rresp;

    assign dbg_state_o = state_q;
    assign dbg_gnt_o   = gnt_q;
    assign dbg_prio_o  = prio_q;

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        prio_d    = prio_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        unique case (state_q)
            IDLE: begin
                if (win_has) begin
                    gnt_d   = win_sel;
                    state_d = win_wr ? WR_REQ : RD_REQ;
                end
            end
            WR_REQ: begin
                // AW and W may complete in either order or together.
                aw_done_d = aw_done_q | aw_hs;
                w_done_d  = w_done_q | w_hs;
                if (aw_done_d && w_done_d) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = WR_RESP;
                end
            end
            WR_RESP: begin
                if (b_hs) begin
                    prio_d  = ~gnt_q;
                    state_d = IDLE;
                end
            end
            RD_REQ: begin
                if (ar_hs) begin
                    state_d = RD_RESP;
                end
            end
            RD_RESP: begin
                if (r_hs) begin
                    prio_d  = ~gnt_q;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q   <= IDLE;
            gnt_q     <= 1'b0;
            prio_q    <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            prio_q    <= prio_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

endmodule

// File: tb/tb_myaccip_axil_arbiter.sv
// Directed bench for myaccip_axil_arbiter: two requester drivers, a four-register slave model
// and negedge monitors feeding per-scenario checks.
module tb_myaccip_axil_arbiter;

    localparam int TMO        = 200;
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WR_RESP = 3'd2;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    myaccip_axil_arbiter_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) s0_if ();
    myaccip_axil_arbiter_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) s1_if ();
    myaccip_axil_arbiter_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) m_if ();

    logic [2:0] dbg_state;
    logic       dbg_gnt;
    logic       dbg_prio;

    myaccip_axil_arbiter #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .WRITE_FIRST(1'b1)) dut (
        .ACLK        (aclk),
        .ARESETN     (aresetn),
        .s0_axi      (s0_if),
        .s1_axi      (s1_if),
        .m_axi       (m_if),
        .dbg_state_o (dbg_state),
        .dbg_gnt_o   (dbg_gnt),
        .dbg_prio_o  (dbg_prio)
    );

    // Requester drive and observe arrays, indexed by requester number.
    logic [3:0]  drv_awaddr[2];
    logic [31:0] drv_wdata[2];
    logic [3:0]  drv_wstrb[2];
    logic        drv_awvalid[2], drv_wvalid[2], drv_bready[2];
    logic [3:0]  drv_araddr[2];
    logic        drv_arvalid[2], drv_rready[2];
    logic        obs_awready[2], obs_wready[2], obs_bvalid[2], obs_arready[2], obs_rvalid[2];
    logic [1:0]  obs_bresp[2];
    logic [31:0] obs_rdata[2];

    assign s0_if.awaddr = drv_awaddr[0];  assign s1_if.awaddr = drv_awaddr[1];
    assign s0_if.awprot = 3'b000;         assign s1_if.awprot = 3'b000;
    assign s0_if.awvalid = drv_awvalid[0]; assign s1_if.awvalid = drv_awvalid[1];
    assign s0_if.wdata = drv_wdata[0];    assign s1_if.wdata = drv_wdata[1];
    assign s0_if.wstrb = drv_wstrb[0];    assign s1_if.wstrb = drv_wstrb[1];
    assign s0_if.wvalid = drv_wvalid[0];  assign s1_if.wvalid = drv_wvalid[1];
    assign s0_if.bready = drv_bready[0];  assign s1_if.bready = drv_bready[1];
    assign s0_if.araddr = drv_araddr[0];  assign s1_if.araddr = drv_araddr[1];
    assign s0_if.arprot = 3'b000;         assign s1_if.arprot = 3'b000;
    assign s0_if.arvalid = drv_arvalid[0]; assign s1_if.arvalid = drv_arvalid[1];
    assign s0_if.rready = drv_rready[0];  assign s1_if.rready = drv_rready[1];

    assign obs_awready[0] = s0_if.awready; assign obs_awready[1] = s1_if.awready;
    assign obs_wready[0]  = s0_if.wready;  assign obs_wready[1]  = s1_if.wready;
    assign obs_bvalid[0]  = s0_if.bvalid;  assign obs_bvalid[1]  = s1_if.bvalid;
    assign obs_bresp[0]   = s0_if.bresp;   assign obs_bresp[1]   = s1_if.bresp;
    assign obs_arready[0] = s0_if.arready; assign obs_arready[1] = s1_if.arready;
    assign obs_rvalid[0]  = s0_if.rvalid;  assign obs_rvalid[1]  = s1_if.rvalid;
    assign obs_rdata[0]   = s0_if.rdata;   assign obs_rdata[1]   = s1_if.rdata;

    // Slave model: four registers, AW can be stalled for aw_stall_cfg offered cycles.
    logic [31:0] regs[4];
    logic        sl_aw_got, sl_w_got, sl_bvalid, sl_rvalid;
    logic [3:0]  sl_aw_addr;
    logic [31:0] sl_wdata, sl_rdata;
    logic [3:0]  sl_wstrb;
    int          sl_aw_wait;
    int          aw_stall_cfg = 0;

    assign m_if.awready = ~sl_aw_got & ~sl_bvalid & (sl_aw_wait >= aw_stall_cfg);
    assign m_if.wready  = ~sl_w_got & ~sl_bvalid;
    assign m_if.bvalid  = sl_bvalid;
    assign m_if.bresp   = 2'b00;
    assign m_if.arready = ~sl_rvalid;
    assign m_if.rvalid  = sl_rvalid;
    assign m_if.rdata   = sl_rdata;
    assign m_if.rresp   = 2'b00;

    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            sl_aw_got <= 1'b0; sl_w_got <= 1'b0; sl_bvalid <= 1'b0; sl_rvalid <= 1'b0;
            sl_aw_wait <= 0;
        end else begin
            if (m_if.awvalid && m_if.awready) begin
                sl_aw_got <= 1'b1; sl_aw_addr <= m_if.awaddr; sl_aw_wait <= 0;
            end else if (m_if.awvalid) begin
                sl_aw_wait <= sl_aw_wait + 1;
            end
            if (m_if.wvalid && m_if.wready) begin
                sl_w_got <= 1'b1; sl_wdata <= m_if.wdata; sl_wstrb <= m_if.wstrb;
            end
            if (sl_aw_got && sl_w_got) begin
                for (int i = 0; i < 4; i++)
                    if (sl_wstrb[i]) regs[sl_aw_addr[3:2]][8*i +: 8] <= sl_wdata[8*i +: 8];
                sl_aw_got <= 1'b0; sl_w_got <= 1'b0; sl_bvalid <= 1'b1;
            end
            if (sl_bvalid && m_if.bready) sl_bvalid <= 1'b0;
            if (m_if.arvalid && m_if.arready) begin
                sl_rvalid <= 1'b1; sl_rdata <= regs[m_if.araddr[3:2]];
            end
            if (sl_rvalid && m_if.rready) sl_rvalid <= 1'b0;
        end
    end

    // Monitors: sampled mid low phase, after the drivers have settled.
    logic [3:0]  maw_q[$];
    logic [31:0] mw_q[$];
    int          ch_q[$];
    int          gnt_log[$];
    int          r_order_q[$];
    int          aw_rdy_cnt[2], w_rdy_cnt[2], bhs_cnt[2], rv_cnt[2];
    int          last_aw_cyc[2], last_w_cyc[2];
    int          s1_act = 0, wr_resp_seen = 0, cyc = 0;

    initial begin
        for (int n = 0; n < 2; n++) begin
            aw_rdy_cnt[n] = 0; w_rdy_cnt[n] = 0; bhs_cnt[n] = 0; rv_cnt[n] = 0;
            last_aw_cyc[n] = 0; last_w_cyc[n] = 0;
        end
    end

    always @(negedge aclk) begin
        #2;
        if (m_if.awvalid && m_if.awready) begin maw_q.push_back(m_if.awaddr); ch_q.push_back(0); end
        if (m_if.wvalid && m_if.wready) mw_q.push_back(m_if.wdata);
        if (m_if.arvalid && m_if.arready) ch_q.push_back(1);
        for (int n = 0; n < 2; n++) begin
            if (obs_awready[n]) begin aw_rdy_cnt[n]++; gnt_log.push_back(n); last_aw_cyc[n] = cyc; end
            if (obs_wready[n]) begin w_rdy_cnt[n]++; last_w_cyc[n] = cyc; end
            if (obs_bvalid[n] && drv_bready[n]) bhs_cnt[n]++;
            if (obs_rvalid[n]) begin rv_cnt[n]++; if (drv_rready[n]) r_order_q.push_back(n); end
        end
        if (s1_if.awready || s1_if.wready || s1_if.bvalid || s1_if.arready || s1_if.rvalid) s1_act++;
        if (dbg_state == ST_WR_RESP) wr_resp_seen++;
        cyc++;
    end

    int n_checks = 0;
    int n_pass = 0;

    // Driver tasks: entered and left on a falling edge.
    task automatic axi_write(input int n, input logic [3:0] addr, input logic [31:0] data,
                             output logic [1:0] resp);
        bit aw_pend = 1'b1, w_pend = 1'b1, hs_aw, hs_w, done = 1'b0;
        int t = 0;
        resp = 2'b11;
        drv_awaddr[n] = addr; drv_wdata[n] = data; drv_wstrb[n] = 4'hF;
        drv_awvalid[n] = 1'b1; drv_wvalid[n] = 1'b1;
        while ((aw_pend || w_pend) && t < TMO) begin
            #1;
            hs_aw = aw_pend && obs_awready[n];
            hs_w  = w_pend && obs_wready[n];
            @(negedge aclk);
            if (hs_aw) begin drv_awvalid[n] = 1'b0; aw_pend = 1'b0; end
            if (hs_w) begin drv_wvalid[n] = 1'b0; w_pend = 1'b0; end
            t++;
        end
        drv_bready[n] = 1'b1;
        while (!done && t < TMO) begin
            #1;
            if (obs_bvalid[n]) begin resp = obs_bresp[n]; done = 1'b1; end
            @(negedge aclk);
            t++;
        end
        drv_bready[n] = 1'b0; drv_awvalid[n] = 1'b0; drv_wvalid[n] = 1'b0;
        n_checks++;
        if (!done) $display("FAIL write_timeout: requester %0d addr %h did not complete, required done", n, addr);
        else n_pass++;
    endtask

    task automatic axi_read(input int n, input logic [3:0] addr, output logic [31:0] data);
        bit pend = 1'b1, hs, done = 1'b0;
        int t = 0;
        data = 32'hDEADBEEF;
        drv_araddr[n] = addr; drv_arvalid[n] = 1'b1; drv_rready[n] = 1'b1;
        while (pend && t < TMO) begin
            #1;
            hs = obs_arready[n];
            @(negedge aclk);
            if (hs) begin drv_arvalid[n] = 1'b0; pend = 1'b0; end
            t++;
        end
        while (!done && t < TMO) begin
            #1;
            if (obs_rvalid[n]) begin data = obs_rdata[n]; done = 1'b1; end
            @(negedge aclk);
            t++;
        end
        drv_rready[n] = 1'b0; drv_arvalid[n] = 1'b0;
        n_checks++;
        if (!done) $display("FAIL read_timeout: requester %0d addr %h did not complete, required done", n, addr);
        else n_pass++;
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
    endtask

    task automatic test_reset();
        @(negedge aclk); #1;
        n_checks++;
        if (dbg_state !== ST_IDLE) $display("FAIL reset_state: got %0d required %0d", dbg_state, ST_IDLE);
        else n_pass++;
        n_checks++;
        if ({dbg_gnt, dbg_prio} !== 2'b00) $display("FAIL reset_gnt_prio: got %b required 00", {dbg_gnt, dbg_prio});
        else n_pass++;
        n_checks++;
        if ({m_if.awvalid, m_if.wvalid, m_if.arvalid, m_if.bready, m_if.rready} !== 5'b0)
            $display("FAIL reset_m_valids: got %b required 00000",
                     {m_if.awvalid, m_if.wvalid, m_if.arvalid, m_if.bready, m_if.rready});
        else n_pass++;
        n_checks++;
        if ({s0_if.awready, s0_if.wready, s0_if.bvalid, s0_if.arready, s0_if.rvalid,
             s1_if.awready, s1_if.wready, s1_if.bvalid, s1_if.arready, s1_if.rvalid} !== 10'b0)
            $display("FAIL reset_s_outputs: got %b required 0",
                     {s0_if.awready, s0_if.wready, s0_if.bvalid, s0_if.arready, s0_if.rvalid,
                      s1_if.awready, s1_if.wready, s1_if.bvalid, s1_if.arready, s1_if.rvalid});
        else n_pass++;
        aresetn = 1'b1;
        @(negedge aclk);
    endtask

    task automatic test_isolated_write();
        logic [1:0] resp;
        int b_aw, b_w, b_s1, b_b0;
        do_reset();
        b_aw = maw_q.size(); b_w = mw_q.size(); b_s1 = s1_act; b_b0 = bhs_cnt[0];
        axi_write(0, 4'h4, 32'h0000_0002, resp);
        repeat (2) @(negedge aclk);
        n_checks++;
        if (maw_q.size() - b_aw !== 1) $display("FAIL iso_aw_count: got %0d required 1", maw_q.size() - b_aw);
        else n_pass++;
        n_checks++;
        if (maw_q.size() > b_aw && maw_q[b_aw] !== 4'h4) $display("FAIL iso_awaddr: got %h required 4", maw_q[b_aw]);
        else n_pass++;
        n_checks++;
        if (mw_q.size() - b_w !== 1) $display("FAIL iso_w_count: got %0d required 1", mw_q.size() - b_w);
        else n_pass++;
        n_checks++;
        if (mw_q.size() > b_w && mw_q[b_w] !== 32'h2) $display("FAIL iso_wdata: got %h required 00000002", mw_q[b_w]);
        else n_pass++;
        n_checks++;
        if (resp !== 2'b00) $display("FAIL iso_bresp: got %b required 00", resp);
        else n_pass++;
        n_checks++;
        if (s1_act - b_s1 !== 0) $display("FAIL iso_s1_quiet: got %0d active cycles required 0", s1_act - b_s1);
        else n_pass++;
        n_checks++;
        if (bhs_cnt[0] - b_b0 !== 1) $display("FAIL iso_b_count: got %0d required 1", bhs_cnt[0] - b_b0);
        else n_pass++;
        n_checks++;
        if (regs[1] !== 32'h2) $display("FAIL iso_slave_reg: got %h required 00000002", regs[1]);
        else n_pass++;
    endtask

    task automatic test_simul_reads();
        logic [1:0]  resp;
        logic [31:0] d0, d1;
        int b_r, b_rv0, b_rv1;
        axi_write(0, 4'h0, 32'h1, resp);
        axi_write(0, 4'h8, 32'h3, resp);
        do_reset();
        b_r = r_order_q.size(); b_rv0 = rv_cnt[0]; b_rv1 = rv_cnt[1];
        fork
            axi_read(0, 4'h0, d0);
            axi_read(1, 4'h8, d1);
        join
        @(negedge aclk);
        n_checks++;
        if (d0 !== 32'h1) $display("FAIL rd_s0_data: got %h required 00000001", d0);
        else n_pass++;
        n_checks++;
        if (d1 !== 32'h3) $display("FAIL rd_s1_data: got %h required 00000003", d1);
        else n_pass++;
        n_checks++;
        if (r_order_q.size() - b_r !== 2 || r_order_q[b_r] !== 0 || r_order_q[b_r+1] !== 1)
            $display("FAIL rd_order: got %0d responses required 2 in order s0,s1", r_order_q.size() - b_r);
        else n_pass++;
        n_checks++;
        if (rv_cnt[0] - b_rv0 !== 1 || rv_cnt[1] - b_rv1 !== 1)
            $display("FAIL rd_rvalid_routing: got s0=%0d s1=%0d required 1 and 1", rv_cnt[0] - b_rv0, rv_cnt[1] - b_rv1);
        else n_pass++;
    endtask

    task automatic test_fairness();
        int b_g, b_b0, b_b1;
        do_reset();
        b_g = gnt_log.size(); b_b0 = bhs_cnt[0]; b_b1 = bhs_cnt[1];
        fork
            begin
                logic [1:0] r0;
                for (int i = 0; i < 8; i++) axi_write(0, 4'(i * 4), 32'h10 + 32'(i), r0);
            end
            begin
                logic [1:0] r1;
                for (int j = 0; j < 8; j++) axi_write(1, 4'(j * 4), 32'h100 + 32'(j), r1);
            end
        join
        repeat (2) @(negedge aclk);
        n_checks++;
        if (gnt_log.size() - b_g !== 16) $display("FAIL fair_grant_count: got %0d required 16", gnt_log.size() - b_g);
        else n_pass++;
        for (int k = 0; k < 16; k++) begin
            if (b_g + k < gnt_log.size()) begin
                n_checks++;
                if (gnt_log[b_g + k] !== k % 2)
                    $display("FAIL fair_grant_%0d: got s%0d required s%0d", k, gnt_log[b_g + k], k % 2);
                else n_pass++;
            end
        end
        n_checks++;
        if (bhs_cnt[0] - b_b0 !== 8 || bhs_cnt[1] - b_b1 !== 8)
            $display("FAIL fair_b_counts: got s0=%0d s1=%0d required 8 and 8", bhs_cnt[0] - b_b0, bhs_cnt[1] - b_b1);
        else n_pass++;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (regs[k] !== 32'h104 + 32'(k)) $display("FAIL fair_reg_%0d: got %h required %h", k, regs[k], 32'h104 + 32'(k));
            else n_pass++;
        end
    endtask

    task automatic test_write_first();
        logic [1:0]  resp;
        logic [31:0] d;
        int b_c;
        do_reset();
        b_c = ch_q.size();
        fork
            axi_write(1, 4'hC, 32'h4, resp);
            axi_read(1, 4'hC, d);
        join
        n_checks++;
        if (ch_q.size() - b_c !== 2 || ch_q[b_c] !== 0 || ch_q[b_c+1] !== 1)
            $display("FAIL wf_order: got %0d requests, first kind %0d, required write then read", ch_q.size() - b_c,
                     (ch_q.size() > b_c) ? ch_q[b_c] : -1);
        else n_pass++;
        n_checks++;
        if (d !== 32'h4) $display("FAIL wf_read_data: got %h required 00000004", d);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [1:0] resp;
        int b_aw, b_w, b_awr, b_wr, b_resp;
        do_reset();
        b_aw = maw_q.size(); b_w = mw_q.size(); b_awr = aw_rdy_cnt[0]; b_wr = w_rdy_cnt[0]; b_resp = wr_resp_seen;
        aw_stall_cfg = 5;
        axi_write(0, 4'h8, 32'hA5, resp);
        aw_stall_cfg = 0;
        n_checks++;
        if (w_rdy_cnt[0] - b_wr !== 1) $display("FAIL bp_wready_pulses: got %0d required 1", w_rdy_cnt[0] - b_wr);
        else n_pass++;
        n_checks++;
        if (aw_rdy_cnt[0] - b_awr !== 1) $display("FAIL bp_awready_pulses: got %0d required 1", aw_rdy_cnt[0] - b_awr);
        else n_pass++;
        n_checks++;
        if (last_aw_cyc[0] - last_w_cyc[0] !== 5)
            $display("FAIL bp_stall_len: got %0d cycles required 5", last_aw_cyc[0] - last_w_cyc[0]);
        else n_pass++;
        n_checks++;
        if (maw_q.size() - b_aw !== 1 || mw_q.size() - b_w !== 1)
            $display("FAIL bp_single_write: got aw=%0d w=%0d required 1 and 1", maw_q.size() - b_aw, mw_q.size() - b_w);
        else n_pass++;
        n_checks++;
        if ((wr_resp_seen - b_resp > 0) !== 1'b1) $display("FAIL bp_wr_resp_reached: got 0 cycles required >0");
        else n_pass++;
    endtask

    task automatic test_reset_in_wr_resp();
        logic [1:0]  resp;
        logic [31:0] d = 32'hDEADBEEF;
        bit reached = 1'b0, hs_aw, hs_w, done = 1'b0;
        int t = 0;
        do_reset();
        axi_write(0, 4'hC, 32'h55, resp);
        #1;
        n_checks++;
        if (dbg_prio !== 1'b1) $display("FAIL rst_prio_before: got %b required 1", dbg_prio);
        else n_pass++;
        @(negedge aclk);
        drv_awaddr[0] = 4'h0; drv_wdata[0] = 32'h77; drv_wstrb[0] = 4'hF;
        drv_awvalid[0] = 1'b1; drv_wvalid[0] = 1'b1; drv_bready[0] = 1'b0;
        while (!reached && t < TMO) begin
            #1;
            if (dbg_state == ST_WR_RESP && obs_bvalid[0]) reached = 1'b1;
            else begin
                hs_aw = obs_awready[0]; hs_w = obs_wready[0];
                @(negedge aclk);
                if (hs_aw) drv_awvalid[0] = 1'b0;
                if (hs_w) drv_wvalid[0] = 1'b0;
                t++;
            end
        end
        n_checks++;
        if (!reached) $display("FAIL rst_reach_wr_resp: got timeout required WR_RESP with bvalid");
        else n_pass++;
        aresetn = 1'b0;
        #1;
        n_checks++;
        if ({m_if.awvalid, m_if.wvalid, m_if.arvalid, m_if.bready, m_if.rready,
             s0_if.awready, s0_if.wready, s0_if.bvalid, s0_if.arready, s0_if.rvalid,
             s1_if.awready, s1_if.wready, s1_if.bvalid, s1_if.arready, s1_if.rvalid} !== 15'b0)
            $display("FAIL rst_async_outputs: got %b required 0",
                     {m_if.awvalid, m_if.wvalid, m_if.arvalid, m_if.bready, m_if.rready,
                      s0_if.awready, s0_if.wready, s0_if.bvalid, s0_if.arready, s0_if.rvalid,
                      s1_if.awready, s1_if.wready, s1_if.bvalid, s1_if.arready, s1_if.rvalid});
        else n_pass++;
        n_checks++;
        if ({dbg_state, dbg_prio} !== {ST_IDLE, 1'b0}) $display("FAIL rst_state_prio: got %h required 0", {dbg_state, dbg_prio});
        else n_pass++;
        drv_awvalid[0] = 1'b0; drv_wvalid[0] = 1'b0;
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        drv_araddr[1] = 4'h4; drv_arvalid[1] = 1'b1; drv_rready[1] = 1'b1;
        @(negedge aclk); #1;
        n_checks++;
        if ({m_if.arvalid, dbg_gnt, m_if.araddr, obs_arready[1]} !== {1'b1, 1'b1, 4'h4, 1'b1})
            $display("FAIL rst_s1_grant_1cycle: got arvalid=%b gnt=%b araddr=%h arready=%b required 1 1 4 1",
                     m_if.arvalid, dbg_gnt, m_if.araddr, obs_arready[1]);
        else n_pass++;
        @(negedge aclk);
        drv_arvalid[1] = 1'b0;
        t = 0;
        while (!done && t < TMO) begin
            #1;
            if (obs_rvalid[1]) begin d = obs_rdata[1]; done = 1'b1; end
            @(negedge aclk);
            t++;
        end
        drv_rready[1] = 1'b0;
        n_checks++;
        if (d !== 32'h105) $display("FAIL rst_s1_read_data: got %h required 00000105", d);
        else n_pass++;
    endtask

    initial begin
        for (int n = 0; n < 2; n++) begin
            drv_awaddr[n] = '0; drv_wdata[n] = '0; drv_wstrb[n] = '0; drv_awvalid[n] = 1'b0;
            drv_wvalid[n] = 1'b0; drv_bready[n] = 1'b0; drv_araddr[n] = '0; drv_arvalid[n] = 1'b0;
            drv_rready[n] = 1'b0;
        end
        test_reset();
        test_isolated_write();
        test_simul_reads();
        test_fairness();
        test_write_first();
        test_backpressure();
        test_reset_in_wr_resp();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit, required completion");
        $fatal(1);
    end

endmodule

// File: doc/myaccip_axil_arbiter.md
# myaccip_axil_arbiter

Two-requester AXI4-Lite round-robin arbiter that shares the single myaccip S00_AXI register port (four 32-bit registers at 0x0, 0x4, 0x8, 0xC) between two independent AXI4-Lite masters.
- It sits between the interconnect and the myaccip slave and serialises whole transactions: one outstanding read or write at a time.
- Response routing is tracked internally, so no ID signals are needed.

## Interface
Parameters:
- ADDR_WIDTH, 4, address width on all three ports (myaccip register window).
- DATA_WIDTH, 32, data width; WSTRB width is DATA_WIDTH/8.
- WRITE_FIRST, 1, when one requester has both a write and a read pending: 1 = write served first, 0 = read served first.

Ports:
- Each `sN_*` line covers s0 and s1. The `m_axi_*` counterpart has the same width and the opposite direction.
- ACLK  in  1  clock; everything sampled on rising edge.
- ARESETN  in  1  reset, asynchronous, active-low.
- sN_axi_awaddr  in  ADDR_WIDTH  write address.
- sN_axi_awprot  in  3  write protection, forwarded unchanged.
- sN_axi_awvalid  in  1  write address valid.
- sN_axi_awready  out  1  write address ready.
- sN_axi_wdata  in  DATA_WIDTH  write data.
- sN_axi_wstrb  in  DATA_WIDTH/8  write strobes.
- sN_axi_wvalid  in  1  write data valid.
- sN_axi_wready  out  1  write data ready.
- sN_axi_bresp  out  2  write response.
- sN_axi_bvalid  out  1  write response valid.
- sN_axi_bready  in  1  write response ready.
- sN_axi_araddr  in  ADDR_WIDTH  read address.
- sN_axi_arprot  in  3  read protection, forwarded unchanged.
- sN_axi_arvalid  in  1  read address valid.
- sN_axi_arready  out  1  read address ready.
- sN_axi_rdata  out  DATA_WIDTH  read data.
- sN_axi_rresp  out  2  read response.
- sN_axi_rvalid  out  1  read data valid.
- sN_axi_rready  in  1  read data ready.

## Operation
FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP. Registered grant `gnt` (0/1); registered priority pointer `prio` (0/1).

Requests:
- Write request of requester N: sN_axi_awvalid & sN_axi_wvalid. AW alone or W alone is not a request.
- Read request of requester N: sN_axi_arvalid.

IDLE arbitration:
- If requester `prio` has any request, it wins; otherwise the other requester wins if it has one.
- The winner's read/write choice follows WRITE_FIRST.
- Register `gnt`, then go to WR_REQ or RD_REQ. No request: stay in IDLE.

WR_REQ:
- m_axi_aw*/w* are driven from `gnt`.
- m_axi_awvalid = ~aw_done; m_axi_wvalid = ~w_done.
- s[gnt]_axi_awready = m_axi_awready & ~aw_done; s[gnt]_axi_wready likewise for W.
- aw_done / w_done set on their respective handshakes, in either order or in the same cycle.
- When both are done, clear the flags and go to WR_RESP.

WR_RESP:
- m_axi_bready = s[gnt]_axi_bready.
- s[gnt]_axi_bvalid/bresp = m_axi_bvalid/bresp.
- On B handshake: prio <= ~gnt, go to IDLE.

RD_REQ:
- m_axi_ar* driven from `gnt`; s[gnt]_axi_arready = m_axi_arready.
- On AR handshake go to RD_RESP.

RD_RESP:
- R channel routed to `gnt` like B. On R handshake: prio <= ~gnt, go to IDLE.

Ungranted requester:
- All its ready/valid outputs are 0; its requests stay pending (AXI stability is its own obligation).
- m_axi_* payload outputs outside the active phase: driven from `gnt` (don't-care), valids 0.
- sN_axi_bresp/rresp/rdata are don't-care when their valid is 0.

Reset (ARESETN low, any state, including mid-transaction):
- State IDLE, prio 0, gnt 0, aw_done/w_done 0.
- All valid and ready outputs 0 immediately (async).
- An in-flight slave transaction is abandoned; the slave is reset by the same ARESETN.

## Timing
- Arbitration: request seen in IDLE at edge k, grant registered at k, m_axi_awvalid/arvalid high in cycle k+1. Minimum 1-cycle added latency per transaction.
- Back-to-back: after the B/R handshake at edge k, state is IDLE in cycle k+1 and the next grant is registered at edge k+1. Transactions are spaced at least 1 idle cycle apart on m_axi.
- Valids and payloads to the slave depend only on registered state plus requester inputs; ready/response paths are combinational pass-through (no added cycle).
- Fairness: with both requesters continuously requesting, grants strictly alternate 0,1,0,1 starting with 0 after reset.

## Test plan
- Isolated write: s0 writes 0x00000002 to 0x4.
  - m_axi_awaddr=0x4, wdata=0x2 seen exactly once.
  - s0_axi_bresp=OKAY; s1 outputs stay 0 throughout.
- Simultaneous reads after reset: s0 reads 0x0, s1 reads 0x8; registers preloaded 1 and 3.
  - s0 served first with rdata=0x1, then s1 with rdata=0x3.
  - No rvalid to the wrong port.
- Fairness: both issue 8 writes back-to-back to 0x0..0xC.
  - m_axi grant order alternates s0,s1,…; each requester receives exactly 8 bvalid pulses.
- Same-requester ordering, WRITE_FIRST=1: s1 presents write 0x4→0xC and read 0xC together.
  - Write completes first; the read returns 0x00000004.
- Backpressure: slave holds awready low 5 cycles while asserting wready.
  - s0_axi_wready pulses once, awready once after the stall; a single write reaches the slave; FSM reaches WR_RESP.
- Reset in WR_RESP: deassert ARESETN while bvalid is pending.
  - All valids/readies 0 within the reset cycle; after release, an s1-only request is granted in 1 cycle and prio restarts at 0.
